// File: rtl/uart_imem_loader.sv
// Loads instruction memory from the UART byte stream: 4 bytes (LSB first) form one word,
// written at consecutive addresses until the terminator word arrives or memory is full.
module uart_imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = 32'hFFFFFFFF,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  input  logic              load_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_timeout,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WRITE   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r, state_nx_s;
  logic [1:0]        idx_r, idx_nx_s;
  logic [23:0]       shift_r, shift_nx_s;
  logic [19:0]       tmo_r, tmo_nx_s;
  logic              we_nx_s;
  logic [ADDR_W-1:0] addr_nx_s;
  logic [31:0]       wdata_nx_s;
  logic              done_nx_s;
  logic [ADDR_W:0]   cnt_nx_s;
  logic              etmo_nx_s;
  logic              eovf_nx_s;
  logic              accept_s;
  logic              tmo_hit_s;
  logic [31:0]       word_s;

  // Byte acceptance is also open during the WRITE cycle so a back-to-back byte 0 is kept
  assign accept_s  = uart_rx_valid && load_en && !uart_rx_break &&
                     ((state_r == S_COLLECT) || (state_r == S_WRITE));
  assign tmo_hit_s = (state_r == S_COLLECT) && (idx_r != 2'd0) &&
                     (tmo_r == (TIMEOUT_CYC - 20'd1));
  assign word_s    = {uart_rx_data, shift_r};

  // Next-state and next-output logic
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    tmo_nx_s   = tmo_r;
    we_nx_s    = 1'b0;
    addr_nx_s  = mem_addr;
    wdata_nx_s = mem_wdata;
    done_nx_s  = write_done;
    cnt_nx_s   = word_count;
    etmo_nx_s  = err_timeout;
    eovf_nx_s  = err_overflow;

    case (state_r)
      S_COLLECT, S_WRITE: begin
        if (state_r == S_WRITE) begin
          state_nx_s = S_COLLECT;
          if (word_count != MEM_WORDS) begin
            cnt_nx_s = word_count + CNT_ONE;
          end else begin
            cnt_nx_s = word_count;
          end
        end else begin
          state_nx_s = S_COLLECT;
        end

        if (!load_en || ((state_r == S_COLLECT) && uart_rx_break)) begin
          idx_nx_s = 2'd0;
          tmo_nx_s = 20'd0;
        end else if (accept_s) begin
          tmo_nx_s = 20'd0;
          idx_nx_s = idx_r + 2'd1;
          case (idx_r)
            2'd0: shift_nx_s[7:0]   = uart_rx_data;
            2'd1: shift_nx_s[15:8]  = uart_rx_data;
            2'd2: shift_nx_s[23:16] = uart_rx_data;
            2'd3: begin
              // Terminator wins over overflow; a full memory drops the word
              if (word_s == END_WORD) begin
                state_nx_s = S_DONE;
                done_nx_s  = 1'b1;
              end else if (word_count == MEM_WORDS) begin
                state_nx_s = S_DONE;
                done_nx_s  = 1'b1;
                eovf_nx_s  = 1'b1;
              end else begin
                state_nx_s = S_WRITE;
                we_nx_s    = 1'b1;
                addr_nx_s  = word_count[ADDR_W-1:0];
                wdata_nx_s = word_s;
              end
            end
            default: idx_nx_s = 2'd0;
          endcase
        end else if (tmo_hit_s) begin
          idx_nx_s  = 2'd0;
          tmo_nx_s  = 20'd0;
          etmo_nx_s = 1'b1;
        end else if ((state_r == S_COLLECT) && (idx_r != 2'd0)) begin
          tmo_nx_s = tmo_r + 20'd1;
        end else begin
          tmo_nx_s = 20'd0;
        end
      end
      S_DONE: begin
        state_nx_s = S_DONE;
      end
      default: begin
        state_nx_s = S_COLLECT;
        idx_nx_s   = 2'd0;
        tmo_nx_s   = 20'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_COLLECT;
      idx_r        <= 2'd0;
      shift_r      <= 24'd0;
      tmo_r        <= 20'd0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= 32'd0;
      write_done   <= 1'b0;
      word_count   <= {(ADDR_W+1){1'b0}};
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      idx_r        <= idx_nx_s;
      shift_r      <= shift_nx_s;
      tmo_r        <= tmo_nx_s;
      mem_we       <= we_nx_s;
      mem_addr     <= addr_nx_s;
      mem_wdata    <= wdata_nx_s;
      write_done   <= done_nx_s;
      word_count   <= cnt_nx_s;
      err_timeout  <= etmo_nx_s;
      err_overflow <= eovf_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader (ADDR_W=2, TIMEOUT_CYC=50).
module tb_uart_imem_loader;

  localparam int          AW  = 2;
  localparam logic [19:0] TMO = 20'd50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx_valid = 1'b0;
  logic [7:0]    uart_rx_data = 8'd0;
  logic          uart_rx_break = 1'b0;
  logic          load_en = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          write_done;
  logic [AW:0]   word_count;
  logic          err_timeout;
  logic          err_overflow;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_we  = 1'b0;

  uart_imem_loader #(.ADDR_W(AW), .END_WORD(32'hFFFFFFFF), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break), .load_en(load_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .write_done(write_done), .word_count(word_count),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_we && mem_we) chk("we_back2back", 32'(mem_we), 32'd0);
      if (mem_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("we_addr", 32'(mem_addr), e.addr);
          chk("we_data", mem_wdata, e.data);
          chk("we_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
    prev_we <= mem_we;
  end

  task automatic pulse(input logic [7:0] b, input bit push, input int addr, input logic [31:0] w);
    exp_t e;
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    if (push) begin
      e.addr = 32'(addr);
      e.data = w;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit push, input int addr);
    for (int i = 0; i < 4; i++) begin
      pulse(w[8*i +: 8], push && (i == 3), addr, w);
      if (i < 3) idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(write_done), 32'd0);
    chk("rst_cnt", 32'(word_count), 32'd0);
    chk("rst_etmo", 32'(err_timeout), 32'd0);
    chk("rst_eovf", 32'(err_overflow), 32'd0);
    idle(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(4);
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    do_reset();

    // Two words back-to-back: second word's byte 0 lands in the WRITE cycle
    send_word(32'hFE010113, 0, 1'b1, 0);
    send_word(32'h00812E23, 0, 1'b1, 1);
    drain("t1_pending");
    chk("t1_cnt", 32'(word_count), 32'd2);
    chk("t1_done", 32'(write_done), 32'd0);

    // Terminator ends loading; later bytes are ignored
    do_reset();
    send_word(32'h00000000, 1, 1'b1, 0);
    send_word(32'hFE010113, 1, 1'b1, 1);
    send_word(32'hFFFFFFFF, 1, 1'b0, 0);
    chk("t2_done_next", 32'(write_done), 32'd1);
    send_word(32'hDDCCBBAA, 1, 1'b0, 0);
    drain("t2_pending");
    chk("t2_cnt", 32'(word_count), 32'd2);
    chk("t2_eovf", 32'(err_overflow), 32'd0);

    // Timeout drops a partial word
    do_reset();
    pulse(8'h13, 1'b0, 0, 32'd0);
    pulse(8'h01, 1'b0, 0, 32'd0);
    idle(40);
    chk("t3_tmo_early", 32'(err_timeout), 32'd0);
    idle(20);
    chk("t3_tmo", 32'(err_timeout), 32'd1);
    send_word(32'h01F00793, 1, 1'b1, 0);
    drain("t3_pending");
    chk("t3_cnt", 32'(word_count), 32'd1);

    // BREAK discards the partial word, coincident byte ignored
    do_reset();
    pulse(8'h13, 1'b0, 0, 32'd0);
    pulse(8'h01, 1'b0, 0, 32'd0);
    uart_rx_break = 1'b1;
    pulse(8'h77, 1'b0, 0, 32'd0);
    uart_rx_break = 1'b0;
    send_word(32'h44332211, 1, 1'b1, 0);
    idle(60);
    drain("t4_pending");
    chk("t4_etmo", 32'(err_timeout), 32'd0);
    chk("t4_cnt", 32'(word_count), 32'd1);

    // Fill all 4 words, the 5th overflows
    do_reset();
    for (int i = 0; i < 4; i++) send_word(32'h10203040 + 32'(i), 1, 1'b1, i);
    send_word(32'hCAFEF00D, 1, 1'b0, 0);
    drain("t5_pending");
    chk("t5_eovf", 32'(err_overflow), 32'd1);
    chk("t5_done", 32'(write_done), 32'd1);
    chk("t5_cnt", 32'(word_count), 32'd4);

    // Reset in the middle of a word
    do_reset();
    send_word(32'h0A0B0C0D, 1, 1'b1, 0);
    pulse(8'hAA, 1'b0, 0, 32'd0);
    pulse(8'hBB, 1'b0, 0, 32'd0);
    drain("t6_pre_pending");
    do_reset();
    send_word(32'h04030201, 1, 1'b1, 0);
    drain("t6_pending");
    chk("t6_cnt", 32'(word_count), 32'd1);

    // load_en low drops partial progress and ignores bytes
    pulse(8'h55, 1'b0, 0, 32'd0);
    pulse(8'h66, 1'b0, 0, 32'd0);
    load_en = 1'b0;
    pulse(8'h77, 1'b0, 0, 32'd0);
    load_en = 1'b1;
    send_word(32'h44332211, 1, 1'b1, 1);
    drain("t7_pending");
    chk("t7_cnt", 32'(word_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
